// File: rtl/game_tick_pkg.sv
// Shared types and default constants for the game tick scheduler.
//   cfg_state_e : config port FSM states (CFG_IDLE, CFG_WAIT)
//   DEF_*       : default sizing for the scheduler and its channels
package game_tick_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_BASE_DIV = 50000;
  localparam int DEF_BASE_W   = 16;
  localparam int DEF_PER_W    = 12;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_WAIT = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: period register, base-tick counter, tick strobe,
// pending/ack handshake and sticky overrun.
// Optional feature macro: TICK_SCHED_OVERRUN_EN (overrun detection).
// Ports:
//   clk, nRst     clock, async active-low reset
//   base_tick_i   shared base-tick strobe
//   en_i          channel enable; 0 holds the counter at 0 and suppresses tick
//   wr_i          apply a config write (period load + counter restart)
//   wr_period_i   period to load on wr_i
//   ack_i         consumer acknowledge, clears pending
//   ovr_clr_i     clears sticky overrun
//   tick_o        one-cycle channel strobe
//   pending_o     set by tick, cleared by ack
//   overrun_o     tick arrived while pending still set and not acked
module tick_channel
  import game_tick_pkg::*;
#(
  parameter int PER_W = DEF_PER_W
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             base_tick_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [PER_W-1:0] wr_period_i,
  input  logic             ack_i,
  input  logic             ovr_clr_i,
  output logic             tick_o,
  output logic             pending_o,
  output logic             overrun_o
);

  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             fire;

  // The base tick that coincides with a config apply is not counted.
  assign fire = base_tick_i && en_i && !wr_i && (period_q != '0) &&
                (cnt_q == period_q - PER_W'(1));

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    if (wr_i) begin
      period_d = wr_period_i;
      cnt_d    = '0;
    end else if (!en_i || (period_q == '0)) begin
      cnt_d = '0;
    end else if (base_tick_i) begin
      cnt_d = fire ? '0 : cnt_q + PER_W'(1);
    end
    tick_d = fire;
    // A new tick keeps pending set even if acked in the same cycle.
    pend_d = pend_q;
    if (fire)       pend_d = 1'b1;
    else if (ack_i) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      period_q <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
    end
  end

  assign tick_o    = tick_q;
  assign pending_o = pend_q;

`ifdef TICK_SCHED_OVERRUN_EN
  logic ovr_q, ovr_d;

  // Set has priority over clear.
  always_comb begin
    ovr_d = ovr_q;
    if (fire && pend_q && !ack_i) ovr_d = 1'b1;
    else if (ovr_clr_i)           ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end

  assign overrun_o = ovr_q;
`else
  logic ovr_clr_unused;
  assign ovr_clr_unused = ovr_clr_i;
  assign overrun_o      = 1'b0;
`endif

endmodule

// File: rtl/game_tick_scheduler.sv
// Shared timebase scheduler: one prescaler produces a base tick every
// BASE_DIV clocks; NUM_CH channels derive programmable-period ticks from it.
// A config port loads channel periods, applied on base-tick boundaries.
// Optional feature macro: TICK_SCHED_OVERRUN_EN (per-channel overrun flags).
// Ports:
//   clk, nRst               clock, async active-low reset
//   run                     global enable; 0 freezes the prescaler
//   ch_en[NUM_CH]           per-channel enable
//   cfg_we/cfg_ch/cfg_period config write request, target, new period
//   cfg_ready               config port idle (write accepted when high)
//   ack[NUM_CH]             clears pending
//   overrun_clr[NUM_CH]     clears sticky overrun
//   base_tick               one-cycle base strobe
//   tick/pending/overrun    per-channel strobe, handshake level, sticky flag
module game_tick_scheduler
  import game_tick_pkg::*;
#(
  parameter  int NUM_CH   = DEF_NUM_CH,
  parameter  int BASE_DIV = DEF_BASE_DIV,
  parameter  int BASE_W   = DEF_BASE_W,
  parameter  int PER_W    = DEF_PER_W,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              run,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [PER_W-1:0]  cfg_period,
  output logic              cfg_ready,
  input  logic [NUM_CH-1:0] ack,
  input  logic [NUM_CH-1:0] overrun_clr,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun
);

  // Prescaler: holds its count while run=0.
  logic [BASE_W-1:0] presc_q, presc_d;
  logic              bt_q, bt_d;

  always_comb begin
    presc_d = presc_q;
    bt_d    = 1'b0;
    if (run) begin
      if (presc_q == BASE_W'(BASE_DIV - 1)) begin
        presc_d = '0;
        bt_d    = 1'b1;
      end else begin
        presc_d = presc_q + BASE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      presc_q <= '0;
      bt_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      bt_q    <= bt_d;
    end
  end

  assign base_tick = bt_q;

  // Config FSM: latch in IDLE, apply in WAIT on the next base tick (or at
  // once when stopped). Writes arriving during WAIT are dropped.
  cfg_state_e       state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [PER_W-1:0] per_q, per_d;
  logic             apply;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    per_d     = per_q;
    apply     = 1'b0;
    cfg_ready = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_we) begin
          ch_d    = cfg_ch;
          per_d   = cfg_period;
          state_d = CFG_WAIT;
        end
      end
      CFG_WAIT: begin
        if (!run || bt_q) begin
          apply   = 1'b1;
          state_d = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= CFG_IDLE;
      ch_q    <= '0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      per_q   <= per_d;
    end
  end

  // An out-of-range cfg_ch matches no channel, so the write is a no-op.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = apply && (32'(ch_q) == i);

    tick_channel #(.PER_W(PER_W)) u_ch (
      .clk        (clk),
      .nRst       (nRst),
      .base_tick_i(bt_q),
      .en_i       (ch_en[i]),
      .wr_i       (wr),
      .wr_period_i(per_q),
      .ack_i      (ack[i]),
      .ovr_clr_i  (overrun_clr[i]),
      .tick_o     (tick[i]),
      .pending_o  (pending[i]),
      .overrun_o  (overrun[i])
    );
  end

endmodule

// File: doc/game_tick_scheduler.md
# game_tick_scheduler

Shared timebase scheduler for the game core. One prescaler divides `clk` into a base tick, and NUM_CH independent channels derive programmable-period tick strobes from it. Example channels: game-logic frame, sprite animation, P1/P2 cooldown timers. Each channel has a pending/ack handshake so consumers can detect missed ticks. A single runtime config port changes channel periods glitch-free on base-tick boundaries.

## Interface
- NUM_CH, 4, number of tick channels (1..8)
- BASE_DIV, 50000, clk cycles per base tick (≥2)
- BASE_W, 16, prescaler width; must hold BASE_DIV-1
- PER_W, 12, channel period/counter width
- clk  in  1  clock
- nRst  in  1  reset, asynchronous, active-low
- run  in  1  global enable; 0 freezes the prescaler, so no base ticks are produced
- ch_en  in  NUM_CH  per-channel enable
- cfg_we  in  1  config write request
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_period  in  PER_W  new period in base ticks; 0 = channel never fires
- cfg_ready  out  1  config port idle, write accepted
- ack  in  NUM_CH  consumer acknowledge, clears pending
- overrun_clr  in  NUM_CH  clears sticky overrun
- base_tick  out  1  one-cycle strobe, every BASE_DIV cycles while run=1
- tick  out  NUM_CH  one-cycle channel strobe
- pending  out  NUM_CH  level, set by tick, cleared by ack
- overrun  out  NUM_CH  sticky: tick arrived while pending still set

## Operation
- Reset values:
  - prescaler 0; all channel counters and periods 0.
  - base_tick, tick, pending and overrun are 0.
  - cfg_ready=1; FSM in IDLE.
- Prescaler:
  - With run=1, it counts 0..BASE_DIV-1. On the terminal count it wraps to 0 and registers base_tick=1 for one cycle.
  - With run=0 it holds its value (no clear) and base_tick=0.
- Channel i update occurs on an edge where base_tick=1, ch_en[i]=1 and period[i]≠0:
  - If cnt==period-1: cnt←0 and tick[i]←1 for one cycle. Otherwise cnt←cnt+1.
- ch_en[i]=0: cnt[i] is held at 0 and tick[i] is suppressed. pending and overrun are retained.
- period 0: cnt is held at 0 and the channel never fires. period 1: the channel fires on every base tick.
- Pending/overrun, evaluated on the edge that sets tick[i]:
  - pending[i]←1.
  - If pending[i]=1 and ack[i]=0, overrun[i]←1.
  - ack[i] in the same cycle as a new tick: pending stays 1 and no overrun is raised.
  - Outside tick edges, ack[i] clears pending[i].
  - overrun_clr[i] clears overrun[i]. A simultaneous set wins.
- Config FSM has two states:
  - IDLE: cfg_ready=1. cfg_we latches cfg_ch/cfg_period and moves to WAIT.
  - WAIT: cfg_ready=0, and cfg_we is ignored (dropped, not queued).
    - If run=0, the write is applied on the next edge.
    - If run=1, it is applied on the edge where base_tick=1.
    - Apply means period[ch]←latched value and cnt[ch]←0. That base tick is not counted for the target channel. Return to IDLE.
- cfg_ch ≥ NUM_CH: the write completes the handshake but changes nothing.

## Timing
- base_tick period is BASE_DIV cycles. The first strobe appears BASE_DIV cycles after run rises from reset state.
- tick[i] lags the base_tick that completes its period by 1 cycle. Channel period is BASE_DIV×P cycles.
- cfg_ready low time is 1 cycle (run=0) or ≤BASE_DIV+1 cycles (run=1).
- Asynchronous reset mid-operation returns every register to its reset value immediately. In-flight config writes are lost.

## Configuration
- TICK_SCHED_OVERRUN_EN defined: the overrun detection described above is implemented.
- Undefined: overrun is tied to 0, overrun_clr is ignored, and the detection logic is removed. pending/ack are unaffected.

## Structure
- Package game_tick_pkg holds:
  - the cfg FSM state enum typedef (CFG_IDLE, CFG_WAIT);
  - default constants for NUM_CH, BASE_DIV and PER_W.
- Sub-module tick_channel contains one channel's period register, counter, tick, pending and overrun logic. It is instantiated NUM_CH times in a generate loop.
- Prescaler and cfg FSM stay in the top level.

## Test plan
All scenarios use BASE_DIV=4, NUM_CH=2, PER_W=4.
- Reset, then run=1 with no config → base_tick every 4 cycles, first at cycle 4 after run; tick=00, cfg_ready=1.
- With run=0, write ch0 period=3 → cfg_ready low exactly 1 cycle. Then run=1 → tick[0] every 12 cycles, 1 cycle after every 3rd base_tick; tick[1]=0.
- Ch0 period 1: ack[0] pulsed with each tick → pending toggles 1→0, overrun=0. Ack coincident with the next tick → pending stays 1, overrun=0.
- No ack across two ch0 ticks → overrun[0]=1 sticky until overrun_clr[0]. Build without TICK_SCHED_OVERRUN_EN → overrun stays 0.
- While running, write ch1 period=2 mid-interval → cfg_ready low until the next base_tick. A second cfg_we during WAIT is dropped. ch1 then ticks every 8 cycles, counted from the apply.
- Drop ch_en[0] mid-period and restore → ch0 counter restarts, so the next tick is a full period later. nRst pulse mid-run → all outputs 0 and cfg_ready=1 within the reset.
